mat_deserializer: RTL and testbench

Collects a row-major stream of W-bit IEEE-754 single-precision words into a packed M×N matrix, using valid/ready handshakes on both sides. It sits directly upstream of mat_transpose and the other linalg operators, and drives their packed `[M-1:0][N-1:0][W-1:0]` matrix input. Framing is checked with `in_last`; malformed frames are discarded and flagged.

---
 rtl/linalg_pkg.sv | 8 +
 rtl/mat_deserializer_if.sv | 29 ++
 rtl/mat_deserializer.sv | 85 ++++++++
 tb/tb_mat_deserializer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/linalg_pkg.sv
// Shared types and widths for the linalg operator family (deserializer, transpose, ...).
package linalg_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;

endpackage : linalg_pkg

// File: rtl/mat_deserializer_if.sv
// Stream-in / matrix-out bundle for mat_deserializer; slave is the deserializer side.
interface mat_deserializer_if
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int W = FP_W
);

    logic [W-1:0]               in_data;
    logic                       in_valid;
    logic                       in_last;
    logic                       in_ready;
    logic [M-1:0][N-1:0][W-1:0] out_mat;
    logic                       out_valid;
    logic                       out_ready;
    logic                       frame_err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_mat, out_valid, frame_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_mat, out_valid, frame_err
    );

endinterface : mat_deserializer_if

// File: rtl/mat_deserializer.sv
// Assembles a row-major element stream into a packed M x N matrix; the first element
// lands in the most-significant word. Frames not ending exactly on element M*N-1 are dropped.
module mat_deserializer
    import linalg_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 3,
    parameter int W = FP_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mat_deserializer_if.slave bus
);

    localparam int ELEMS = M * N;
    localparam int CW    = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(ELEMS - 1);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_FULL = 1'b1;

    logic [0:0]                state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic [ELEMS-1:0][W-1:0]   mat_q, mat_d;
    logic                      frame_err_q, frame_err_d;
    logic                      accept;
    logic [CW-1:0]             wr_idx;

    // Handshake outputs come straight from the state register.
    assign bus.in_ready  = (state_q == S_FILL);
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.out_mat   = mat_q;
    assign bus.frame_err = frame_err_q;

    assign accept = bus.in_valid && (state_q == S_FILL);
    assign wr_idx = LAST_IDX - count_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mat_d       = mat_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_FILL: begin
                if (accept) begin
                    mat_d[wr_idx] = bus.in_data;
                    if ((count_q == LAST_IDX) && bus.in_last) begin
                        count_d = '0;
                        state_d = S_FULL;
                    end else if ((count_q == LAST_IDX) || bus.in_last) begin
                        // Partial words stay in storage; they are overwritten by the next frame.
                        count_d     = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (bus.out_ready) begin
                    state_d = S_FILL;
                end
            end
            default: begin
                state_d = S_FILL;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            count_q     <= '0;
            mat_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mat_q       <= mat_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule : mat_deserializer

// File: tb/tb_mat_deserializer.sv
// Directed and randomly gapped stimulus for mat_deserializer (M=2, N=3, W=32).
module tb_mat_deserializer;

    localparam int M        = 2;
    localparam int N        = 3;
    localparam int W        = 32;
    localparam int ELEMS    = M * N;
    localparam int MAT_BITS = ELEMS * W;
    localparam int RAND_FRAMES = 100;

    logic clk;
    logic rst_n;

    int checkCount;
    int failCount;

    logic [W-1:0] frameOne[ELEMS];
    logic [W-1:0] frameTwo[ELEMS];
    logic [W-1:0] frameThree[ELEMS];
    logic [W-1:0] randWords[RAND_FRAMES*ELEMS];

    mat_deserializer_if #(.M(M), .N(N), .W(W)) bus ();

    mat_deserializer #(.M(M), .N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [MAT_BITS-1:0] got,
                               input logic [MAT_BITS-1:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Element 0 of the stream occupies the most-significant word.
    function automatic logic [MAT_BITS-1:0] packFrame(input logic [W-1:0] words[ELEMS]);
        logic [MAT_BITS-1:0] r;
        r = '0;
        for (int e = 0; e < ELEMS; e++) r[(ELEMS-1-e)*W +: W] = words[e];
        return r;
    endfunction

    function automatic logic [MAT_BITS-1:0] transposeMat(input logic [MAT_BITS-1:0] m);
        logic [MAT_BITS-1:0] t;
        t = '0;
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++)
                t[(ELEMS-1-(c*M+r))*W +: W] = m[(ELEMS-1-(r*N+c))*W +: W];
        return t;
    endfunction

    // Called in the negedge phase; presents one beat across the next rising edge.
    task automatic applyStimulus(input logic [W-1:0] data, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_last  = last;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic sendFrame(input logic [W-1:0] words[ELEMS]);
        for (int e = 0; e < ELEMS; e++) applyStimulus(words[e], e == ELEMS - 1);
    endtask

    task automatic doHandshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_valid_after_hs"}, MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        checkOutput({tag, "_ready_after_hs"}, MAT_BITS'(bus.in_ready), MAT_BITS'(1));
    endtask

    initial begin : mainSeq
        logic [MAT_BITS-1:0] held;
        logic [MAT_BITS-1:0] expMat;
        logic [W-1:0]        win[ELEMS];
        int beatIdx;
        int framesOut;
        int cycles;
        int errSeen;

        checkCount = 0;
        failCount  = 0;
        frameOne   = '{32'h3F800000, 32'h40000000, 32'h40400000,
                       32'h40800000, 32'h40A00000, 32'h40C00000};
        frameTwo   = '{32'h11111111, 32'h22222222, 32'h33333333,
                       32'h44444444, 32'h55555555, 32'h66666666};
        frameThree = '{32'hA0000001, 32'hB0000002, 32'hC0000003,
                       32'hD0000004, 32'hE0000005, 32'hF0000006};
        for (int i = 0; i < RAND_FRAMES*ELEMS; i++) randWords[i] = $urandom;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        #3;
        checkOutput("rst_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        checkOutput("rst_frame_err", MAT_BITS'(bus.frame_err), MAT_BITS'(0));
        checkOutput("rst_out_mat", bus.out_mat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", MAT_BITS'(bus.in_ready), MAT_BITS'(1));

        // Basic frame
        sendFrame(frameOne);
        checkOutput("basic_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("basic_in_ready", MAT_BITS'(bus.in_ready), MAT_BITS'(0));
        checkOutput("basic_out_mat", bus.out_mat,
                    192'h3F800000_40000000_40400000_40800000_40A00000_40C00000);
        checkOutput("basic_transpose", transposeMat(bus.out_mat),
                    192'h3F800000_40800000_40000000_40A00000_40400000_40C00000);

        // Backpressure with the source holding element 0 of the next frame
        held = bus.out_mat;
        bus.in_valid = 1'b1;
        bus.in_data  = frameTwo[0];
        bus.in_last  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_in_ready", MAT_BITS'(bus.in_ready), MAT_BITS'(0));
            checkOutput("bp_out_mat", bus.out_mat, held);
        end
        doHandshake("bp");
        sendFrame(frameTwo);
        checkOutput("bp_next_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("bp_next_mat", bus.out_mat, packFrame(frameTwo));
        doHandshake("bp_next");

        // Early last on the 4th beat
        for (int e = 0; e < 4; e++) applyStimulus(frameThree[e], e == 3);
        checkOutput("early_frame_err", MAT_BITS'(bus.frame_err), MAT_BITS'(1));
        checkOutput("early_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        @(posedge clk);
        @(negedge clk);
        checkOutput("early_err_pulse", MAT_BITS'(bus.frame_err), MAT_BITS'(0));
        checkOutput("early_no_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        sendFrame(frameOne);
        checkOutput("early_recover_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("early_recover_mat", bus.out_mat, packFrame(frameOne));
        doHandshake("early");

        // Missing last: 6 beats without in_last, then a proper frame
        for (int e = 0; e < ELEMS; e++) applyStimulus(frameTwo[e], 1'b0);
        checkOutput("miss_frame_err", MAT_BITS'(bus.frame_err), MAT_BITS'(1));
        checkOutput("miss_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        sendFrame(frameThree);
        checkOutput("miss_err_cleared", MAT_BITS'(bus.frame_err), MAT_BITS'(0));
        checkOutput("miss_next_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("miss_next_mat", bus.out_mat, packFrame(frameThree));
        doHandshake("miss");

        // Asynchronous reset mid-fill
        for (int e = 0; e < 3; e++) applyStimulus(frameTwo[e], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstfill_out_mat", bus.out_mat, '0);
        checkOutput("rstfill_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        checkOutput("rstfill_in_ready", MAT_BITS'(bus.in_ready), MAT_BITS'(1));
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(frameOne);
        checkOutput("rstfill_after_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("rstfill_after_mat", bus.out_mat, packFrame(frameOne));

        // Asynchronous reset while FULL
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstfull_out_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(0));
        checkOutput("rstfull_in_ready", MAT_BITS'(bus.in_ready), MAT_BITS'(1));
        checkOutput("rstfull_out_mat", bus.out_mat, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sendFrame(frameTwo);
        checkOutput("rstfull_after_valid", MAT_BITS'(bus.out_valid), MAT_BITS'(1));
        checkOutput("rstfull_after_mat", bus.out_mat, packFrame(frameTwo));
        doHandshake("rstfull");

        // Randomly gapped source and sink; registered ready/valid are stable in the negedge phase
        beatIdx   = 0;
        framesOut = 0;
        cycles    = 0;
        errSeen   = 0;
        while (framesOut < RAND_FRAMES && cycles < 20000) begin
            if (bus.frame_err) errSeen++;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (bus.out_valid && bus.out_ready) begin
                for (int e = 0; e < ELEMS; e++) win[e] = randWords[framesOut*ELEMS + e];
                expMat = packFrame(win);
                checkOutput($sformatf("rand_frame_%0d", framesOut), bus.out_mat, expMat);
                framesOut++;
            end
            if (beatIdx < RAND_FRAMES*ELEMS) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = randWords[beatIdx];
                bus.in_last  = ((beatIdx % ELEMS) == ELEMS - 1);
                if (bus.in_valid && bus.in_ready) beatIdx++;
            end else begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("rand_frames_done", MAT_BITS'(framesOut), MAT_BITS'(RAND_FRAMES));
        checkOutput("rand_no_frame_err", MAT_BITS'(errSeen), MAT_BITS'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule : tb_mat_deserializer
